// File: rtl/level_speed_ticker_if.sv
// Level-in / movement-strobe bundle between the level counter, ticker and motion logic.
// The master drives level and enable; the slave (the ticker) returns tick and level status.
interface level_speed_ticker_if;
   logic [1:0] level_in;
   logic       enable;
   logic       tick;
   logic [1:0] level_used;
   logic       level_chg;

   modport master (
      output level_in,
      output enable,
      input  tick,
      input  level_used,
      input  level_chg
   );

   modport slave (
      input  level_in,
      input  enable,
      output tick,
      output level_used,
      output level_chg
   );
endinterface

// File: rtl/level_speed_ticker.sv
// Turns the async 2-bit difficulty level into a one-cycle movement tick of period (4-L)*BASE_PERIOD.
// Level reaches level_stable 3 edges after first sample; no backpressure, tick is a free-running strobe.
module level_speed_ticker #(
   parameter int BASE_PERIOD = 500000,
   parameter int CNT_W       = 24
) (
   input logic           clk,
   input logic           reset,
   level_speed_ticker_if.slave bus
);

   localparam logic [CNT_W-1:0] RESET_CNT = CNT_W'(4 * BASE_PERIOD - 1);

   logic [1:0]       s1;
   logic [1:0]       s2;
   logic [1:0]       s3;
   logic [1:0]       level_stable;
   logic [1:0]       level_used;
   logic [CNT_W-1:0] cnt;
   logic             tick;
   logic             level_chg;

   // Reload value for a level: (4 - L) * BASE_PERIOD - 1, evaluated at CNT_W bits.
   function automatic logic [CNT_W-1:0] reload_val(input logic [1:0] lvl);
      logic [CNT_W-1:0] mult;
      mult = CNT_W'(3'd4 - {1'b0, lvl});
      return mult * CNT_W'(BASE_PERIOD) - CNT_W'(1);
   endfunction

   // Two-flop synchronizer plus a history flop; a multi-bit skew sample never
   // repeats on consecutive edges, so requiring s2 == s3 filters it out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1           <= 2'b00;
         s2           <= 2'b00;
         s3           <= 2'b00;
         level_stable <= 2'b00;
      end else begin
         s1 <= bus.level_in;
         s2 <= s1;
         s3 <= s2;
         if (s2 == s3) begin
            level_stable <= s2;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= RESET_CNT;
         tick       <= 1'b0;
         level_used <= 2'b00;
         level_chg  <= 1'b0;
      end else if (!bus.enable) begin
         // Idle: keep a full period armed so enabling never yields an early tick.
         tick       <= 1'b0;
         cnt        <= reload_val(level_stable);
         level_used <= level_stable;
         level_chg  <= (level_stable != level_used);
      end else if (cnt == '0) begin
         tick       <= 1'b1;
         cnt        <= reload_val(level_stable);
         level_used <= level_stable;
         level_chg  <= (level_stable != level_used);
      end else begin
         tick      <= 1'b0;
         cnt       <= cnt - CNT_W'(1);
         level_chg <= 1'b0;
      end
   end

   assign bus.tick       = tick;
   assign bus.level_used = level_used;
   assign bus.level_chg  = level_chg;

endmodule
